// File: rtl/lis3dh_pkg.sv
// lis3dh_pkg: LIS3DH register addresses, SPI command bits and reader FSM states
package lis3dh_pkg;
  localparam logic [7:0] CTRL_REG1 = 8'h20;
  localparam logic [7:0] CTRL_REG3 = 8'h22;
  localparam logic [7:0] OUT_X_L   = 8'h28;
  localparam logic [7:0] READ      = 8'h80;
  localparam logic [7:0] MULTI     = 8'h40;
  typedef enum logic [2:0] {
    S_PWRUP, S_WR1, S_GAP1, S_WR3, S_GAP2, S_IDLE, S_RD, S_DONE
  } state_e;
endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: SPI mode 3 single-byte shifter; owns SCLK, MOSI and the bit-rate divider
module spi_byte_shifter #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d;
  logic act_q, act_d, sclk_q, sclk_d, mosi_q, mosi_d, tick;
  assign tick = act_q && cnt_q == CW'(CLK_DIV - 1);
  // done lands on the last half-period boundary so a chained start keeps the bit rate seamless
  assign done = tick && sclk_q && bit_q == 3'd7;
  assign rx_byte = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  always_comb begin
    cnt_d = act_q && !tick ? cnt_q + 1'b1 : '0;
    bit_d = bit_q;
    sh_d = sh_q;
    rx_d = rx_q;
    act_d = act_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    if (tick && !sclk_q) begin
      sclk_d = 1'b1;
      rx_d = {rx_q[6:0], miso};
    end else if (tick && bit_q != 3'd7) begin
      sclk_d = 1'b0;
      mosi_d = sh_q[7];
      sh_d = {sh_q[6:0], 1'b0};
      bit_d = bit_q + 3'd1;
    end else if (done) begin
      act_d = 1'b0;
    end
    if (start) begin
      act_d = 1'b1;
      sclk_d = 1'b0;
      mosi_d = tx_byte[7];
      sh_d = {tx_byte[6:0], 1'b0};
      bit_d = 3'd0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bit_q <= 3'd0;
      sh_q <= 8'h00;
      rx_q <= 8'h00;
      act_q <= 1'b0;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      act_q <= act_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end
endmodule

// File: rtl/lis3dh_spi_reader.sv
// lis3dh_spi_reader: configures a LIS3DH over SPI and reads X/Y/Z on every data-ready interrupt
module lis3dh_spi_reader
  import lis3dh_pkg::*;
#(
  parameter int         CLK_DIV       = 25,
  parameter int         PWRUP_CYCLES  = 250000,
  parameter logic [7:0] CTRL_REG1_VAL = 8'h57,
  parameter logic [7:0] CTRL_REG3_VAL = 8'h10
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        int1,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_sclk,
  output logic        spi_ss_n,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0] bidx_q, bidx_d, nbyte, last;
  logic [1:0] sync_q, sync_d;
  logic [47:0] rdata_q, rdata_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0] tx_byte, rx_byte;
  logic go_q, go_d, ss_n_q, ss_n_d, valid_q, valid_d, init_q, init_d;
  logic xfer, start, done, gap_end;
  spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk(clk_clk), .rst_n(reset_reset_n), .start(start), .tx_byte(tx_byte), .miso(spi_miso),
    .rx_byte(rx_byte), .done(done), .sclk(spi_sclk), .mosi(spi_mosi)
  );
  assign xfer = state_q inside {S_WR1, S_WR3, S_RD};
  assign last = state_q == S_RD ? 3'd6 : 3'd1;
  assign nbyte = go_q ? bidx_q + 3'd1 : 3'd0;
  // first byte starts CLK_DIV cycles after ss_n falls; later bytes chain off the previous done
  assign start = xfer && (go_q ? done && bidx_q != last : cnt_q == 32'(CLK_DIV - 1));
  assign tx_byte = state_q == S_WR1 ? (nbyte == 3'd0 ? CTRL_REG1 : CTRL_REG1_VAL)
                 : state_q == S_WR3 ? (nbyte == 3'd0 ? CTRL_REG3 : CTRL_REG3_VAL)
                 : (nbyte == 3'd0 ? (READ | MULTI | OUT_X_L) : 8'h00);
  assign gap_end = cnt_q == 32'(2 * CLK_DIV - 1);
  assign spi_ss_n = ss_n_q;
  assign sample_x = x_q;
  assign sample_y = y_q;
  assign sample_z = z_q;
  assign sample_valid = valid_q;
  assign init_done = init_q;
  assign busy = state_q != S_IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 32'd1;
    bidx_d = bidx_q;
    go_d = go_q;
    ss_n_d = ss_n_q;
    valid_d = 1'b0;
    init_d = init_q;
    rdata_d = rdata_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    sync_d = {sync_q[0], int1};
    if (start) begin
      go_d = 1'b1;
      bidx_d = nbyte;
    end
    if (done && state_q == S_RD && bidx_q != 3'd0) rdata_d = {rx_byte, rdata_q[47:8]};
    case (state_q)
      S_PWRUP: if (cnt_q == 32'(PWRUP_CYCLES - 1)) begin
        state_d = S_WR1;
        cnt_d = '0;
        ss_n_d = 1'b0;
      end
      S_WR1, S_WR3, S_RD: if (done && bidx_q == last) begin
        state_d = state_q == S_WR1 ? S_GAP1 : state_q == S_WR3 ? S_GAP2 : S_DONE;
        go_d = 1'b0;
        ss_n_d = 1'b1;
        cnt_d = '0;
      end
      S_GAP1: if (gap_end) begin
        state_d = S_WR3;
        cnt_d = '0;
        ss_n_d = 1'b0;
      end
      S_GAP2: if (gap_end) begin
        state_d = S_IDLE;
        init_d = 1'b1;
      end
      S_IDLE: if (sync_q[1]) begin
        state_d = S_RD;
        cnt_d = '0;
        ss_n_d = 1'b0;
      end
      S_DONE: begin
        state_d = S_GAP2;
        cnt_d = '0;
        valid_d = 1'b1;
        x_d = rdata_q[15:0];
        y_d = rdata_q[31:16];
        z_d = rdata_q[47:32];
      end
      default: state_d = S_PWRUP;
    endcase
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_PWRUP;
      cnt_q <= '0;
      bidx_q <= 3'd0;
      go_q <= 1'b0;
      ss_n_q <= 1'b1;
      valid_q <= 1'b0;
      init_q <= 1'b0;
      rdata_q <= '0;
      x_q <= 16'h0000;
      y_q <= 16'h0000;
      z_q <= 16'h0000;
      sync_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bidx_q <= bidx_d;
      go_q <= go_d;
      ss_n_q <= ss_n_d;
      valid_q <= valid_d;
      init_q <= init_d;
      rdata_q <= rdata_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      sync_q <= sync_d;
    end
  end
endmodule

// File: tb/tb_lis3dh_spi_reader.sv
// tb_lis3dh_spi_reader: directed bench with an SPI slave model and a cycle-level protocol checker
module tb_lis3dh_spi_reader;
  localparam int D = 2;
  localparam int PW = 10;
  logic clk = 1'b0, rst_n = 1'b0, int1 = 1'b0, miso = 1'b0;
  logic mosi, sclk, ss_n, valid, init_done, busy;
  logic [15:0] sx, sy, sz;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  lis3dh_spi_reader #(.CLK_DIV(D), .PWRUP_CYCLES(PW)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .int1(int1), .spi_miso(miso), .spi_mosi(mosi),
    .spi_sclk(sclk), .spi_ss_n(ss_n), .sample_x(sx), .sample_y(sy), .sample_z(sz),
    .sample_valid(valid), .init_done(init_done), .busy(busy)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask
  typedef struct {int n; logic [55:0] d;} txn_t;
  txn_t txq[$];
  logic [7:0] resp[6];
  logic [7:0] sent[6];
  int nbits = 0;
  logic [55:0] sdata = '0;
  logic s_ss = 1'b1, s_sclk = 1'b1;
  // mode-3 slave: drives MISO on SCLK fall, captures MOSI on SCLK rise, logs completed transactions
  always @(ss_n or sclk) begin
    if (s_ss && !ss_n) begin
      nbits = 0;
      sdata = '0;
      sent = resp;
      miso = 1'b0;
    end else if (!s_ss && ss_n) begin
      if (rst_n) txq.push_back('{nbits, sdata});
    end else if (!ss_n && s_sclk && !sclk) begin
      miso = nbits / 8 == 0 ? 1'b0 : sent[nbits / 8 - 1][7 - nbits % 8];
    end else if (!ss_n && !s_sclk && sclk) begin
      sdata = {sdata[54:0], mosi};
      nbits++;
    end
    s_ss = ss_n;
    s_sclk = sclk;
  end
  int run = 0, hi = 0, rises = 0, wr = 0, reads = 0;
  logic p_ss = 1'b1, p_sclk = 1'b1, exp_v = 1'b0, seen_init = 1'b0;
  logic [47:0] p_s = '0;
  // protocol model: phase lengths, CS gaps, strobe timing, sample contents and hold, init/busy rules
  always @(negedge clk) begin
    if (!rst_n) begin
      p_ss = 1'b1; p_sclk = 1'b1; exp_v = 1'b0; seen_init = 1'b0;
      p_s = '0; run = 0; hi = 0; rises = 0; wr = 0;
    end else begin
      chk("valid_timing", valid, exp_v);
      exp_v = 1'b0;
      if (valid) chk("sample_value", {sx, sy, sz}, {sent[1], sent[0], sent[3], sent[2], sent[5], sent[4]});
      else chk("sample_hold", {sx, sy, sz}, p_s);
      p_s = {sx, sy, sz};
      if (ss_n) chk("sclk_idle_high", sclk, 1'b1);
      if (!busy) chk("idle_flags", {ss_n, init_done}, 2'b11);
      if (wr < 2) chk("init_early", init_done, 1'b0);
      else if (seen_init || !ss_n) chk("init_sticky", init_done, 1'b1);
      seen_init = seen_init | init_done;
      if (p_ss && !ss_n) begin
        chk("cs_gap", hi >= 2 * D, 1'b1);
        run = 1;
        rises = 0;
      end else if (!p_ss && (ss_n || sclk != p_sclk)) begin
        chk("sclk_phase", run, D);
        run = 1;
      end else run++;
      if (!ss_n && !p_sclk && sclk) rises++;
      if (!p_ss && ss_n) begin
        if (rises == 16) wr++;
        if (rises == 56) begin
          reads++;
          exp_v = 1'b1;
        end
      end
      hi = ss_n ? hi + 1 : 0;
      p_ss = ss_n;
      p_sclk = sclk;
    end
  end
  task automatic get_txn(output txn_t t);
    for (int k = 0; k < 2000 && txq.size() == 0; k++) @(posedge clk);
    chk("txn_arrival", txq.size() != 0, 1'b1);
    t = txq.size() != 0 ? txq.pop_front() : '{0, '0};
  endtask
  task automatic wait_valid();
    for (int k = 0; k < 2000 && !valid; k++) @(negedge clk);
    chk("valid_arrival", valid, 1'b1);
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
    chk("idle_arrival", busy, 1'b0);
  endtask
  task automatic wait_cs_low();
    for (int k = 0; k < 2000 && ss_n; k++) @(negedge clk);
    chk("cs_low_arrival", ss_n, 1'b0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ss_sclk_mosi"}, {ss_n, sclk, mosi}, 3'b110);
    chk({tag, "_samples"}, {sx, sy, sz}, 48'h0);
    chk({tag, "_valid_init_busy"}, {valid, init_done, busy}, 3'b001);
  endtask
  localparam logic [55:0] RD_CMD = 56'hE8_0000_0000_0000;
  txn_t t;
  int nr;
  initial begin
    resp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    int1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    get_txn(t);
    chk("wr1_bytes", {t.n[7:0], t.d}, {8'd16, 56'h2057});
    chk("wr1_no_init", init_done, 1'b0);
    get_txn(t);
    chk("wr3_bytes", {t.n[7:0], t.d}, {8'd16, 56'h2210});
    @(negedge clk);
    chk("wr3_init_pending", init_done, 1'b0);
    wait_cs_low();
    int1 = 1'b0;
    get_txn(t);
    chk("rd1_bytes", {t.n[7:0], t.d}, {8'd56, RD_CMD});
    wait_valid();
    chk("rd1_x", sx, 16'h0201);
    chk("rd1_y", sy, 16'h0403);
    chk("rd1_z", sz, 16'h0605);
    @(negedge clk);
    chk("rd1_valid_one_cycle", valid, 1'b0);
    repeat (200) @(negedge clk);
    chk("single_read", reads, 1);
    resp = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h34, 8'h12};
    int1 = 1'b1;
    repeat (3) @(negedge clk);
    int1 = 1'b0;
    get_txn(t);
    chk("rd2_bytes", {t.n[7:0], t.d}, {8'd56, RD_CMD});
    wait_valid();
    chk("rd2_x", sx, 16'hFF00);
    chk("rd2_y", sy, 16'h7F80);
    chk("rd2_z", sz, 16'h1234);
    wait_idle();
    chk("rd2_count", reads, 2);
    resp = '{8'hAA, 8'h55, 8'hC3, 8'h3C, 8'hFE, 8'h01};
    int1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_txn(t);
      chk("held_rd_bytes", {t.n[7:0], t.d}, {8'd56, RD_CMD});
    end
    int1 = 1'b0;
    wait_idle();
    nr = txq.size();
    for (int i = 0; i < nr; i++) begin
      t = txq.pop_front();
      chk("held_tail_bytes", {t.n[7:0], t.d}, {8'd56, RD_CMD});
    end
    chk("held_read_count", reads >= 5, 1'b1);
    chk("held_last_x", sx, 16'h55AA);
    resp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int1 = 1'b1;
    wait_cs_low();
    int1 = 1'b0;
    for (int k = 0; k < 2000 && nbits < 30; k++) @(negedge clk);
    chk("bit30_reached", nbits >= 30, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrd_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midrd_held");
    rst_n = 1'b1;
    get_txn(t);
    chk("re_wr1_bytes", {t.n[7:0], t.d}, {8'd16, 56'h2057});
    get_txn(t);
    chk("re_wr3_bytes", {t.n[7:0], t.d}, {8'd16, 56'h2210});
    wait_idle();
    chk("re_init_done", init_done, 1'b1);
    chk("re_no_partial_sample", {sx, sy, sz}, 48'h0);
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end
endmodule
